// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, imem requester and IF/ID register with one-entry skid buffer
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2,
  output logic        valid_out,
  output logic        halted,
  output logic        err
);
  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc2_q, pc2_d;
  logic        valid_q, valid_d;
  logic [15:0] buf_instr_q, buf_instr_d;
  logic [15:0] buf_pc2_q, buf_pc2_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;
  logic        accept;
  logic [15:0] pc_inc;

  // rst gates the request so an in-flight fetch is abandoned immediately
  assign imem_req  = (state_q == FETCH) & ~redirect & ~rst;
  assign imem_addr = {pc_q[15:1], 1'b0};
  assign accept    = imem_req & imem_ready;
  assign pc_inc    = pc_q + 16'd2;
  assign instr     = instr_q;
  assign pc_plus2  = pc2_q;
  assign valid_out = valid_q;
  assign halted    = halted_q;
  assign err       = err_q;

  // next-state: redirect beats stall beats normal flow
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc2_d       = pc2_q;
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc2_d   = buf_pc2_q;
    halted_d    = (state_q == HALTED) & ~redirect;
    err_d       = err_q | (redirect & redirect_pc[0]);
    if (redirect) begin
      pc_d        = redirect_pc & 16'hFFFE;
      instr_d     = NOP_INSTR;
      valid_d     = 1'b0;
      buf_instr_d = NOP_INSTR;
      buf_pc2_d   = 16'h0000;
      state_d     = FETCH;
    end else if (state_q == FETCH) begin
      if (accept) begin
        pc_d = pc_inc;
        if (stall) begin
          buf_instr_d = imem_rdata;
          buf_pc2_d   = pc_inc;
          state_d     = HOLD;
        end else begin
          instr_d = imem_rdata;
          pc2_d   = pc_inc;
          valid_d = 1'b1;
          state_d = (imem_rdata[15:11] == HALT_OPC) ? HALTED : FETCH;
        end
      end else if (!stall) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end else if (!stall) begin
      instr_d = (state_q == HOLD) ? buf_instr_q : NOP_INSTR;
      pc2_d   = (state_q == HOLD) ? buf_pc2_q : pc2_q;
      valid_d = (state_q == HOLD);
      state_d = (state_q == HOLD && buf_instr_q[15:11] != HALT_OPC) ? FETCH : HALTED;
    end
  end

  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pc2_q       <= 16'h0000;
      valid_q     <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc2_q   <= 16'h0000;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc2_q       <= pc2_d;
      valid_q     <= valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc2_q   <= buf_pc2_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed fetch scenarios checked against a queue-based model and literals
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        rdy = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] instr;
  logic [15:0] pc_plus2;
  logic        valid_out;
  logic        halted;
  logic        err;
  logic [15:0] mem [0:32767];
  int          n_chk = 0;
  int          n_fail = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .instr(instr), .pc_plus2(pc_plus2), .valid_out(valid_out), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[15:1]];
  assign imem_ready = imem_req & rdy;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: IF/ID contents, pending skid words and a stopped flag
  logic [15:0] m_pc, m_instr, m_pc2;
  logic        m_valid, m_halted, m_err, m_stopped;
  logic [31:0] skid [$];

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0800; m_pc2 = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0; m_stopped = 1'b0;
    skid.delete();
  endtask

  task automatic model_step();
    logic        req;
    logic [15:0] w;
    logic [31:0] e;
    req = (skid.size() == 0) && !m_stopped && !redirect;
    if (redirect) begin
      m_err = m_err | redirect_pc[0];
      m_pc = {redirect_pc[15:1], 1'b0};
      m_instr = 16'h0800; m_valid = 1'b0;
      skid.delete(); m_stopped = 1'b0; m_halted = 1'b0;
    end else begin
      m_halted = m_stopped;
      if (req && rdy) begin
        w = mem[m_pc[15:1]];
        if (stall) skid.push_back({w, m_pc + 16'd2});
        else begin
          m_instr = w; m_pc2 = m_pc + 16'd2; m_valid = 1'b1;
          if (w[15:11] == 5'b00000) m_stopped = 1'b1;
        end
        m_pc = m_pc + 16'd2;
      end else if (!stall) begin
        if (skid.size() != 0) begin
          e = skid.pop_front();
          m_instr = e[31:16]; m_pc2 = e[15:0]; m_valid = 1'b1;
          if (e[31:27] == 5'b00000) m_stopped = 1'b1;
        end else begin
          m_instr = 16'h0800; m_valid = 1'b0;
        end
      end
    end
  endtask

  // compare every cycle mid-period, then advance the model for the coming edge
  always @(negedge clk) begin
    if (rst) model_reset();
    chk("instr", instr, m_instr);
    chk("pc_plus2", pc_plus2, m_pc2);
    chk("valid_out", {15'd0, valid_out}, {15'd0, m_valid});
    chk("halted", {15'd0, halted}, {15'd0, m_halted});
    chk("err", {15'd0, err}, {15'd0, m_err});
    chk("imem_req", {15'd0, imem_req},
        {15'd0, !rst && skid.size() == 0 && !m_stopped && !redirect});
    chk("imem_addr", imem_addr, m_pc);
    if (!rst) model_step();
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [39:0] pat_s, pat_r;
    for (int i = 0; i < 32768; i++) mem[i] = 16'hC800 + 16'(i);
    mem[0] = 16'hC001; mem[1] = 16'hC102; mem[2] = 16'hC203; mem[3] = 16'hC304;
    mem[4] = 16'hC405; mem[8] = 16'h0000;
    step(); step();
    rst = 1'b0;
    step(); chk("seq0_instr", instr, 16'hC001); chk("seq0_pc2", pc_plus2, 16'h0002);
    chk("seq0_valid", {15'd0, valid_out}, 16'd1); chk("seq0_addr", imem_addr, 16'h0002);
    step(); chk("seq1_instr", instr, 16'hC102); chk("seq1_pc2", pc_plus2, 16'h0004);
    rdy = 1'b0;
    step(); chk("wait0_instr", instr, 16'h0800); chk("wait0_valid", {15'd0, valid_out}, 16'd0);
    chk("wait0_addr", imem_addr, 16'h0004);
    step(); chk("wait1_instr", instr, 16'h0800); chk("wait1_addr", imem_addr, 16'h0004);
    rdy = 1'b1;
    step(); chk("wait_done_instr", instr, 16'hC203); chk("wait_done_pc2", pc_plus2, 16'h0006);
    step(); chk("seq3_instr", instr, 16'hC304); chk("seq3_addr", imem_addr, 16'h0008);
    stall = 1'b1;
    step(); chk("skid_hold_instr", instr, 16'hC304); chk("skid_hold_pc2", pc_plus2, 16'h0008);
    chk("skid_req", {15'd0, imem_req}, 16'd0);
    step(); step();
    stall = 1'b0;
    step(); chk("skid_out_instr", instr, 16'hC405); chk("skid_out_pc2", pc_plus2, 16'h000A);
    chk("skid_out_valid", {15'd0, valid_out}, 16'd1); chk("skid_out_addr", imem_addr, 16'h000A);
    step();
    stall = 1'b1;
    step(); chk("hold_req", {15'd0, imem_req}, 16'd0);
    redirect = 1'b1; redirect_pc = 16'h0100;
    step(); redirect = 1'b0; stall = 1'b0; #1;
    chk("flush_instr", instr, 16'h0800); chk("flush_valid", {15'd0, valid_out}, 16'd0);
    chk("flush_addr", imem_addr, 16'h0100); chk("flush_req", {15'd0, imem_req}, 16'd1);
    step(); chk("tgt_instr", instr, 16'hC880); chk("tgt_pc2", pc_plus2, 16'h0102);
    redirect = 1'b1; redirect_pc = 16'h000E;
    step(); redirect = 1'b0;
    step(); chk("pre_halt_instr", instr, 16'hC807); chk("pre_halt_pc2", pc_plus2, 16'h0010);
    step(); chk("halt_instr", instr, 16'h0000); chk("halt_valid", {15'd0, valid_out}, 16'd1);
    chk("halt_not_yet", {15'd0, halted}, 16'd0); chk("halt_req", {15'd0, imem_req}, 16'd0);
    step(); chk("halted_set", {15'd0, halted}, 16'd1); chk("halted_bubble", instr, 16'h0800);
    repeat (3) step();
    chk("halted_req", {15'd0, imem_req}, 16'd0); chk("halted_stay", {15'd0, halted}, 16'd1);
    redirect = 1'b1; redirect_pc = 16'h0020;
    step(); redirect = 1'b0; #1;
    chk("resume_halted", {15'd0, halted}, 16'd0); chk("resume_addr", imem_addr, 16'h0020);
    step(); chk("resume_instr", instr, 16'hC810); chk("resume_pc2", pc_plus2, 16'h0022);
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step(); redirect = 1'b0; #1;
    chk("mis_err", {15'd0, err}, 16'd1); chk("mis_addr", imem_addr, 16'hFFFE);
    step(); chk("wrap_instr", instr, 16'h47FF); chk("wrap_pc2", pc_plus2, 16'h0000);
    chk("wrap_addr", imem_addr, 16'h0000);
    step(); chk("wrap_next", instr, 16'hC001);
    pat_s = 40'h3_0C61_8C30; pat_r = 40'hF_B7DE_9F6D;
    for (int i = 0; i < 40; i++) begin
      stall = pat_s[i]; rdy = pat_r[i];
      step();
    end
    stall = 1'b0; rdy = 1'b1;
    chk("err_sticky", {15'd0, err}, 16'd1);
    rst = 1'b1; #1;
    chk("arst_err", {15'd0, err}, 16'd0); chk("arst_req", {15'd0, imem_req}, 16'd0);
    chk("arst_instr", instr, 16'h0800);
    step(); step();
    rst = 1'b0;
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register, directly upstream of decode. Owns the PC and issues requests to a variable-latency instruction memory. Presents the fetched instruction and PC+2 to decode. Handles decode-hazard stalls with a one-entry skid buffer, branch/jump redirects with flush, and HALT detection.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0800, bubble encoding driven on instr during flush or empty cycles.
HALT_OPC, 5'b00000, value of instr[15:11] that marks HALT.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  decode hazard hold; IF/ID must not advance.
redirect  in  1  branch/jump taken; flush and reload PC.
redirect_pc  in  16  target PC, valid with redirect.
imem_req  out  1  fetch request, held until accepted.
imem_addr  out  16  fetch address, equal to PC with bit0 cleared, stable while imem_req is high.
imem_rdata  in  16  instruction word, valid in the cycle imem_ready is high.
imem_ready  in  1  memory response for the current request.
instr  out  16  IF/ID instruction to decode.
pc_plus2  out  16  IF/ID PC+2 of instr.
valid_out  out  1  instr is a real fetched instruction, not a bubble.
halted  out  1  stage has stopped fetching after HALT.
err  out  1  sticky misaligned-redirect flag.

Behaviour:
- Reset, asynchronous: pc=RESET_PC, state=FETCH, instr=NOP_INSTR, pc_plus2=0, valid_out=0, buffer empty, halted=0, err=0.
- Outputs: imem_req=1 only in state FETCH and not redirect; imem_addr={pc[15:1],1'b0}, driven combinationally from the PC register. All other outputs are registered.
- A response is accepted when imem_req and imem_ready are both high, and there is no redirect.
- Withdrawing imem_req cancels the outstanding request. Memory never returns ready for a withdrawn request.
- States: FETCH, HOLD, HALTED.
- Priority each cycle: redirect > stall > normal.
- redirect, any state:
  - pc<=redirect_pc & 16'hFFFE; err<=1 if redirect_pc[0].
  - IF/ID<=NOP_INSTR with valid_out=0; buffer cleared; halted<=0; state<=FETCH.
  - Any same-cycle imem_ready is discarded.
- FETCH, accept, stall=0:
  - IF/ID<={imem_rdata, pc+2}, valid_out=1; pc<=pc+2.
  - State<=HALTED if imem_rdata[15:11]==HALT_OPC, else FETCH.
- FETCH, accept, stall=1:
  - Buffer<={imem_rdata, pc+2}; pc<=pc+2; state<=HOLD.
  - IF/ID holds its contents.
- FETCH, no accept, stall=0: IF/ID<=NOP_INSTR, valid_out=0 (bubble).
- FETCH, no accept, stall=1: IF/ID holds.
- HOLD:
  - imem_req=0.
  - While stall=1, everything holds.
  - When stall=0: IF/ID<=buffer, valid_out=1; state<=HALTED if the buffered word is HALT, else FETCH.
- HALTED:
  - No requests; halted=1 (registered, asserted the cycle after HALT enters IF/ID).
  - With stall=0, IF/ID<=NOP_INSTR, valid_out=0. With stall=1, IF/ID holds.
  - Only redirect or rst leaves HALTED.
- PC arithmetic: 16-bit unsigned, wraps 16'hFFFE+2=16'h0000, and pc_plus2 wraps likewise.
- Latency: a zero-wait memory (ready in the request cycle) gives one instruction per cycle. instr appears at the IF/ID output on the clock edge following acceptance.
- Reset mid-request: the request drops immediately (asynchronous); the memory must tolerate the abandoned request.
- err clears only on rst.

Test Plan:
- Zero-wait sequential fetch from reset: ready=1 every cycle, mem[0..6]=0xC001,0xC102,0xC203,0xC304 -> instr sequence as listed with pc_plus2=2,4,6,8 and valid_out=1 from the first edge; imem_addr=0,2,4,6.
- Wait states: ready low for 2 cycles on address 0x0004 -> two bubbles with instr=0x0800 and valid_out=0; imem_addr held at 0x0004 throughout; then the instr from 0x0004 appears with pc_plus2=0x0006.
- Stall with skid: stall=1 for 3 cycles while the response for 0x0008 arrives -> IF/ID holds the prior instr, imem_req drops, and on stall release instr=mem[8] with pc_plus2=0x000A; no duplicate or lost word.
- Redirect during stall and wait: redirect=1 with redirect_pc=0x0100 while in HOLD -> next cycle instr=0x0800, valid_out=0, imem_addr=0x0100; the buffered word is never emitted.
- HALT and recovery: mem[0x0010]=0x0000 -> HALT issued with valid_out=1, then halted=1 with no further imem_req; a later redirect to 0x0020 resumes fetch with halted=0.
- Misaligned redirect and wrap: redirect_pc=0xFFFF -> err=1, imem_addr=0xFFFE, next fetch addr=0x0000 and pc_plus2=0x0000; err stays 1 until rst.
